// File: rtl/scan_temp_classifier_pkg.sv
// rtl/scan_temp_classifier_pkg.sv - shared constants and FSM encoding for the scan-code temperature classifier
//
// Package scan_temp_pkg
//   SC_0 .. SC_9   : PS/2 make codes for the decimal digits 0-9
//   SCAN_INVALID   : digit value reported by the decoder for any non-digit code
//   state_t        : controller states IDLE / CONVERT / CLASSIFY
package scan_temp_pkg;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  // Never a legal decimal digit, so it cannot be mistaken for one downstream.
  localparam logic [3:0] SCAN_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONVERT  = 2'd1,
    CLASSIFY = 2'd2
  } state_t;

endpackage

// File: rtl/scan_temp_classifier_if.sv
// rtl/scan_temp_classifier_if.sv - entry/result bundle between keyboard capture, classifier and fan/heater control
//
// Signals
//   in_valid      : entry offered on SCAN_CODES
//   in_ready      : classifier idle, entry will be accepted
//   SCAN_CODES    : NUM_DIGITS make codes, byte 0 = units digit
//   TempDecsalida : one-hot band of the last good entry
//   temp_value    : binary value of the last good entry
//   out_valid     : one-cycle result/error pulse
//   scan_err      : qualifies out_valid, entry held a non-digit code
// Modports
//   master : entry source (keyboard side)
//   slave  : classifier
interface scan_temp_classifier_if #(
  parameter int NUM_DIGITS = 2,
  parameter int NUM_BANDS  = 4,
  parameter int VAL_W      = 7
);

  logic                    in_valid;
  logic                    in_ready;
  logic [8*NUM_DIGITS-1:0] SCAN_CODES;
  logic [NUM_BANDS-1:0]    TempDecsalida;
  logic [VAL_W-1:0]        temp_value;
  logic                    out_valid;
  logic                    scan_err;

  modport master (
    output in_valid, SCAN_CODES,
    input  in_ready, TempDecsalida, temp_value, out_valid, scan_err
  );

  modport slave (
    input  in_valid, SCAN_CODES,
    output in_ready, TempDecsalida, temp_value, out_valid, scan_err
  );

endinterface

// File: rtl/scan_temp_classifier_digit_decode.sv
// rtl/scan_temp_classifier_digit_decode.sv - combinational PS/2 make code to decimal digit decoder
//
// Ports
//   code  in  8 : make code of one key
//   digit out 4 : decimal value 0-9, SCAN_INVALID when code is not a digit key
//   valid out 1 : code is one of the ten digit keys
module scan_digit_decode (
  input  logic [7:0] code,
  output logic [3:0] digit,
  output logic       valid
);

  import scan_temp_pkg::*;

  always_comb begin
    digit = SCAN_INVALID;
    valid = 1'b1;
    case (code)
      SC_0:    digit = 4'd0;
      SC_1:    digit = 4'd1;
      SC_2:    digit = 4'd2;
      SC_3:    digit = 4'd3;
      SC_4:    digit = 4'd4;
      SC_5:    digit = 4'd5;
      SC_6:    digit = 4'd6;
      SC_7:    digit = 4'd7;
      SC_8:    digit = 4'd8;
      SC_9:    digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/scan_temp_classifier.sv
// rtl/scan_temp_classifier.sv - digit-serial scan-code to binary converter with one-hot band classification
//
// Converts NUM_DIGITS PS/2 make codes (MSD first, one digit per cycle) into a
// binary setpoint and classifies it against the ascending THRESH table.
// Optional hysteresis on downward band moves: define SCAN_TEMP_HYST_EN.
//
// Ports
//   CLK    in : system clock
//   reset  in : asynchronous active-high reset
//   bus       : scan_temp_classifier_if.slave (in_valid/in_ready/SCAN_CODES in,
//               TempDecsalida/temp_value/out_valid/scan_err out)
module scan_temp_classifier #(
  parameter int NUM_DIGITS = 2,
  parameter int NUM_BANDS  = 4,
  parameter int VAL_W      = 7,
  parameter logic [(NUM_BANDS-1)*VAL_W-1:0] THRESH = {7'd60, 7'd40, 7'd20},
  parameter int HYST       = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  scan_temp_classifier_if.slave bus
);

  import scan_temp_pkg::*;

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef SCAN_TEMP_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  state_t                  state, state_nx;
  logic [8*NUM_DIGITS-1:0] codes_q;
  logic [CW-1:0]           dig_cnt;
  logic [VAL_W-1:0]        acc;
  logic                    err;
  logic [BW-1:0]           cur_band;
  logic                    band_valid;   // no band is held until the first good entry

  logic [7:0]              sel_code;
  logic [3:0]              dig;
  logic                    dig_ok;
  logic [3:0]              dig_use;
  logic [VAL_W+3:0]        acc_mul;
  logic [VAL_W:0]          val_ext;
  logic [VAL_W:0]          val_hyst;
  logic [BW-1:0]           raw_now;
  logic [BW-1:0]           raw_hi;
  logic [BW-1:0]           new_band;
  logic [NUM_BANDS-1:0]    new_onehot;

  // Band = number of thresholds at or below v (table is ascending).
  function automatic logic [BW-1:0] raw_band(input logic [VAL_W:0] v);
    raw_band = '0;
    for (int i = 0; i < NUM_BANDS-1; i++) begin
      if (v >= {1'b0, THRESH[i*VAL_W +: VAL_W]}) raw_band = BW'(i+1);
    end
  endfunction

  // dig_cnt counts down so the most significant byte is consumed first.
  assign sel_code = codes_q[{dig_cnt, 3'b000} +: 8];

  scan_digit_decode u_decode (
    .code  (sel_code),
    .digit (dig),
    .valid (dig_ok)
  );

  assign dig_use = dig_ok ? dig : 4'd0;
  // acc*10 + 9 always fits in VAL_W+4 bits; the result is truncated to VAL_W.
  assign acc_mul = {4'b0000, acc} * (VAL_W+4)'(10) + {{VAL_W{1'b0}}, dig_use};

  // One extra bit so val+HYST cannot wrap into a lower band.
  assign val_ext  = {1'b0, acc};
  assign val_hyst = val_ext + (VAL_W+1)'(HYST);
  assign raw_now  = raw_band(val_ext);
  assign raw_hi   = raw_band(val_hyst);

  // Upward (or same-band) moves follow the raw band; downward moves settle at
  // min(cur, raw(val+HYST)), i.e. only drop once val clears the margin.
  always_comb begin
    new_band = raw_now;
    if (HYST_ON && band_valid && (raw_now <= cur_band)) begin
      new_band = (raw_hi < cur_band) ? raw_hi : cur_band;
    end
  end

  assign new_onehot = {{(NUM_BANDS-1){1'b0}}, 1'b1} << new_band;

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.in_valid) state_nx = CONVERT;
      CONVERT:  if (dig_cnt == '0) state_nx = CLASSIFY;
      CLASSIFY: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready = (state == IDLE);
  end

  // Datapath and registered results
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      codes_q           <= '0;
      dig_cnt           <= '0;
      acc               <= '0;
      err               <= 1'b0;
      cur_band          <= '0;
      band_valid        <= 1'b0;
      bus.TempDecsalida <= '0;
      bus.temp_value    <= '0;
      bus.out_valid     <= 1'b0;
      bus.scan_err      <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.scan_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            codes_q <= bus.SCAN_CODES;
            acc     <= '0;
            err     <= 1'b0;
            dig_cnt <= CW'(NUM_DIGITS-1);
          end
        end
        CONVERT: begin
          acc     <= acc_mul[VAL_W-1:0];
          dig_cnt <= dig_cnt - CW'(1);
          if (!dig_ok) err <= 1'b1;
        end
        CLASSIFY: begin
          bus.out_valid <= 1'b1;
          if (err) begin
            bus.scan_err <= 1'b1;
          end else begin
            bus.temp_value    <= acc;
            bus.TempDecsalida <= new_onehot;
            cur_band          <= new_band;
            band_valid        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_temp_classifier.sv
// tb/tb_scan_temp_classifier.sv - self-checking bench for scan_temp_classifier
module tb_scan_temp_classifier;

  localparam int NUM_DIGITS = 2;
  localparam int NUM_BANDS  = 4;
  localparam int VAL_W      = 7;
  localparam int HYST       = 3;
  localparam int LAT        = NUM_DIGITS + 1;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  scan_temp_classifier_if #(.NUM_DIGITS(NUM_DIGITS), .NUM_BANDS(NUM_BANDS), .VAL_W(VAL_W)) bus ();

  scan_temp_classifier #(
    .NUM_DIGITS (NUM_DIGITS),
    .NUM_BANDS  (NUM_BANDS),
    .VAL_W      (VAL_W),
    .THRESH     ({7'd60, 7'd40, 7'd20}),
    .HYST       (HYST)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sc_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] bad_tab [3] = '{8'h1C, 8'hF0, 8'h00};
  int         th [NUM_BANDS-1] = '{20, 40, 60};

  // Reference state: last good value and band (-1 = no band yet).
  int m_value = 0;
  int m_band  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (sc_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic int raw_band(input int v);
    int b = 0;
    for (int i = 0; i < NUM_BANDS-1; i++) if (v >= th[i]) b++;
    return b;
  endfunction

  function automatic int m_onehot();
    return (m_band < 0) ? 0 : (1 << m_band);
  endfunction

  // Decimal value of the entry, then band update of the reference.
  task automatic model_apply(input logic [8*NUM_DIGITS-1:0] codes, output bit err);
    int val = 0;
    int r;
    int nb;
    err = 1'b0;
    for (int pos = 0; pos < NUM_DIGITS; pos++) begin
      int d = digit_of(codes[pos*8 +: 8]);
      if (d < 0) err = 1'b1;
      else       val += d * (10 ** pos);
    end
    val = val % (1 << VAL_W);
    if (!err) begin
      r = raw_band(val);
      if (m_band < 0 || r >= m_band) begin
        m_band = r;
      end else begin
`ifdef SCAN_TEMP_HYST_EN
        nb = m_band;
        while (nb > 0 && val + HYST < th[nb-1]) nb--;
        m_band = nb;
`else
        nb = r;
        m_band = nb;
`endif
      end
      m_value = val;
    end
  endtask

  task automatic run_entry(input logic [8*NUM_DIGITS-1:0] codes, input string tag);
    bit err;
    int edges;
    @(negedge CLK);
    check({tag, "_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.SCAN_CODES = codes;
    @(posedge CLK);
    #1;
    // Keep in_valid up with junk codes for one busy edge: it must be ignored.
    bus.SCAN_CODES = 16'($urandom);
    model_apply(codes, err);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 10) begin
      check({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
      @(posedge CLK);
      #1;
      edges++;
      if (edges == 1) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"},  32'(edges),             32'(LAT));
    check({tag, "_out_valid"}, 32'(bus.out_valid),    32'd1);
    check({tag, "_scan_err"},  32'(bus.scan_err),     32'(err));
    check({tag, "_value"},     32'(bus.temp_value),   32'(m_value));
    check({tag, "_band"},      32'(bus.TempDecsalida), 32'(m_onehot()));
    @(posedge CLK);
    #1;
    check({tag, "_pulse_end"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_post"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*NUM_DIGITS-1:0] dir [8];
    logic [8*NUM_DIGITS-1:0] rc;
    dir = '{16'h161E, 16'h4646, 16'h4545, 16'h2545, 16'h252E, 16'h263E, 16'h2636, 16'h1C1E};

    bus.in_valid   = 1'b0;
    bus.SCAN_CODES = '0;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready",     32'(bus.in_ready),  32'd1);
    reset = 1'b0;
    repeat (5) begin
      @(posedge CLK);
      #1;
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("idle_band",  32'(bus.TempDecsalida), 32'd0);
    check("idle_value", 32'(bus.temp_value),    32'd0);
    check("idle_ready", 32'(bus.in_ready),      32'd1);
    check("idle_err",   32'(bus.scan_err),      32'd0);

    // Directed: 12, 99, 00, 40, 45, 38, 36, invalid
    run_entry(dir[0], "d12");
    check("d12_band_lit", 32'(bus.TempDecsalida), 32'b0001);
    run_entry(dir[1], "d99");
    check("d99_band_lit", 32'(bus.TempDecsalida), 32'b1000);
    run_entry(dir[2], "d00");
    check("d00_band_lit", 32'(bus.TempDecsalida), 32'b0001);
    run_entry(dir[3], "d40");
    check("d40_band_lit", 32'(bus.TempDecsalida), 32'b0100);
    run_entry(dir[4], "d45");
    run_entry(dir[5], "d38");
`ifdef SCAN_TEMP_HYST_EN
    check("d38_band_lit", 32'(bus.TempDecsalida), 32'b0100);
`else
    check("d38_band_lit", 32'(bus.TempDecsalida), 32'b0010);
`endif
    check("d38_value_lit", 32'(bus.temp_value), 32'd38);
    run_entry(dir[6], "d36");
    check("d36_band_lit", 32'(bus.TempDecsalida), 32'b0010);
    run_entry(dir[7], "dbad");
    check("dbad_value_lit", 32'(bus.temp_value), 32'd36);

    // Random entries, occasional non-digit byte
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < NUM_DIGITS; p++) begin
        if ($urandom_range(0, 9) == 0) rc[p*8 +: 8] = bad_tab[$urandom_range(0, 2)];
        else                           rc[p*8 +: 8] = sc_tab[$urandom_range(0, 9)];
      end
      run_entry(rc, "rnd");
    end

    // Reset one edge after accepting 27 aborts the conversion
    @(negedge CLK);
    bus.in_valid   = 1'b1;
    bus.SCAN_CODES = 16'h1E3D;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    #1;
    check("arst_band",      32'(bus.TempDecsalida), 32'd0);
    check("arst_value",     32'(bus.temp_value),    32'd0);
    check("arst_out_valid", 32'(bus.out_valid),     32'd0);
    check("arst_err",       32'(bus.scan_err),      32'd0);
    check("arst_ready",     32'(bus.in_ready),      32'd1);
    m_value = 0;
    m_band  = -1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (6) begin
      @(posedge CLK);
      #1;
      check("arst_no_pulse", 32'(bus.out_valid), 32'd0);
    end
    run_entry(16'h3E26, "d83");
    check("d83_band_lit", 32'(bus.TempDecsalida), 32'b1000);
    check("d83_value_lit", 32'(bus.temp_value), 32'd83);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_temp_classifier.md
Name: scan_temp_classifier

Overview:
- Parametrised successor to the two-digit keyboard temperature decoder.
- Accepts NUM_DIGITS PS/2 make scan codes that form a decimal temperature setpoint. Converts them digit-serially to binary, then classifies the value into NUM_BANDS one-hot bands, with optional hysteresis.
- Sits between the PS/2 keyboard capture logic and the fan/heater control logic.

Parameters:
- NUM_DIGITS, 2: number of decimal digits per entry.
- NUM_BANDS, 4: number of output bands. Width of the one-hot output.
- VAL_W, 7: binary value width. Must hold 10^NUM_DIGITS-1.
- THRESH, {7'd60,7'd40,7'd20}: (NUM_BANDS-1) packed VAL_W-bit ascending thresholds, field 0 at the LSBs.
- HYST, 3: hysteresis margin. Used only with HYST_EN.

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  SCAN_CODES valid.
- in_ready  out  1  block idle; can accept an entry.
- SCAN_CODES  in  8*NUM_DIGITS  scan codes. Byte 0 = units, byte NUM_DIGITS-1 = most significant digit.
- TempDecsalida  out  NUM_BANDS  one-hot band of the last good entry.
- temp_value  out  VAL_W  binary value of the last good entry.
- out_valid  out  1  one-cycle pulse when a result or an error is posted.
- scan_err  out  1  one-cycle pulse with out_valid; entry contained a non-digit code.

Behaviour:
- Reset values (asynchronous):
  - TempDecsalida=0, temp_value=0, out_valid=0, scan_err=0, in_ready=1.
  - State IDLE; current band = none.
- Digit table:
  - 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - Any other byte is invalid.
- FSM IDLE:
  - in_ready=1.
  - in_valid at an edge (edge 0): capture SCAN_CODES, clear accumulator and err flag, go to CONVERT.
- FSM CONVERT (NUM_DIGITS cycles, MSD first):
  - acc <= acc*10 + digit, truncated to VAL_W.
  - An invalid byte sets a sticky err flag and contributes 0.
  - A digit counter selects the byte; after the last digit, go to CLASSIFY.
- FSM CLASSIFY (edge NUM_DIGITS+1):
  - If err: scan_err=1, out_valid=1. TempDecsalida and temp_value hold.
  - Else: temp_value=acc, TempDecsalida=onehot(new band), out_valid=1.
  - Return to IDLE.
- Latency: out_valid is visible after edge NUM_DIGITS+1. This is 3 edges for the default parameters.
- in_ready is low from edge 0 through CLASSIFY. in_valid while busy is ignored (not queued).
- Back-to-back: a new accept is allowed on the edge at which out_valid drops.
- Raw band: band i where THRESH[i-1] <= val < THRESH[i]. Band 0 when below THRESH[0]; top band when val >= THRESH[NUM_BANDS-2]. A value equal to a threshold goes to the upper band.
- The first good entry after reset sets the band directly (no hysteresis).
- Reset mid-operation aborts the conversion: no out_valid, and all outputs return to reset values.

Optional Feature:
- Macro: SCAN_TEMP_HYST_EN.
- Defined:
  - Upward band moves are immediate.
  - Downward moves use new = min(cur, raw(val+HYST)). The band drops only when val < THRESH[cur-1]-HYST. val+HYST is computed at VAL_W+1 bits.
- Undefined: new = raw(val). The HYST parameter is unused.

Decomposition:
- Package scan_temp_pkg: scan-code localparams for digits 0-9, SCAN_INVALID marker, FSM state encoding (IDLE, CONVERT, CLASSIFY).
- Sub-module scan_digit_decode: combinational, 8-bit code in → 4-bit digit out plus valid. Instantiated once on the currently selected byte.

Test Plan:
- Reset, then idle 5 cycles → TempDecsalida=0000, temp_value=0, in_ready=1, no out_valid.
- SCAN_CODES={0x16,0x1E} (12) with in_valid for one cycle → out_valid after 3 edges, temp_value=12, TempDecsalida=0001. in_ready is low for those cycles.
- Entry 99 ({0x46,0x46}) → 1000. Then 00 ({0x45,0x45}) → 0001. Then 40 ({0x25,0x45}) → 0100 (threshold boundary).
- With SCAN_TEMP_HYST_EN:
  - 45 ({0x25,0x2E}) → 0100.
  - 38 ({0x26,0x3E}) → stays 0100, temp_value=38.
  - 36 ({0x26,0x36}) → 0010.
  - Without the macro, 38 → 0010.
- Invalid entry {0x1C,0x1E} → out_valid=1, scan_err=1. TempDecsalida and temp_value unchanged from the previous entry.
- Accept 27, then assert reset one edge later → all outputs reset, no out_valid. A new entry of 83 afterwards → 1000, latency 3 edges.
